// File: rtl/aes_core_arbiter_pkg.sv
// Shared constants for the AES core arbiter: widths, requester limit, FSM state codes
// and the round-robin pointer advance.
package aes_ctrl_pkg;

  localparam int AES_BLK_W = 128;
  localparam int REQ_ID_W  = 2;
  localparam int MAX_REQ   = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LAUNCH = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_RESP   = 3'd3;

  // Next round-robin start position after serving requester id out of n.
  function automatic logic [REQ_ID_W-1:0] rr_next(input logic [REQ_ID_W-1:0] id, input int n);
    logic [REQ_ID_W-1:0] nxt;
    if (int'(id) >= n - 1) begin
      nxt = '0;
    end else begin
      nxt = id + REQ_ID_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/aes_core_arbiter_if.sv
// Host request ports, AES core ports and response port of the arbiter, bundled.
// slave is the arbiter's view; master is the view of the surrounding logic.
interface aes_core_arbiter_if #(
  parameter int N_REQ = 2
) ();

  logic [N_REQ-1:0]                          pi_req_valid;
  logic [N_REQ*aes_ctrl_pkg::AES_BLK_W-1:0]  pi_req_key;
  logic [N_REQ*aes_ctrl_pkg::AES_BLK_W-1:0]  pi_req_data;
  logic [N_REQ-1:0]                          po_req_ready;
  logic [aes_ctrl_pkg::AES_BLK_W-1:0]        po_core_key;
  logic [aes_ctrl_pkg::AES_BLK_W-1:0]        po_core_data;
  logic                                      po_core_start;
  logic                                      po_core_key_change;
  logic                                      pi_core_done;
  logic [aes_ctrl_pkg::AES_BLK_W-1:0]        pi_core_data;
  logic                                      po_rsp_valid;
  logic [aes_ctrl_pkg::REQ_ID_W-1:0]         po_rsp_id;
  logic [aes_ctrl_pkg::AES_BLK_W-1:0]        po_rsp_data;
  logic                                      po_rsp_error;
  logic                                      pi_rsp_ready;
  logic                                      po_busy;

  modport slave (
    input  pi_req_valid, pi_req_key, pi_req_data, pi_core_done, pi_core_data, pi_rsp_ready,
    output po_req_ready, po_core_key, po_core_data, po_core_start, po_core_key_change,
           po_rsp_valid, po_rsp_id, po_rsp_data, po_rsp_error, po_busy
  );

  modport master (
    output pi_req_valid, pi_req_key, pi_req_data, pi_core_done, pi_core_data, pi_rsp_ready,
    input  po_req_ready, po_core_key, po_core_data, po_core_start, po_core_key_change,
           po_rsp_valid, po_rsp_id, po_rsp_data, po_rsp_error, po_busy
  );

endinterface

// File: rtl/aes_core_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping around.
module aes_rr_arbiter
  import aes_ctrl_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]    req,
  input  logic [REQ_ID_W-1:0] ptr,
  input  logic                en,
  output logic [N_REQ-1:0]    grant,
  output logic [REQ_ID_W-1:0] idx
);

  logic [MAX_REQ-1:0]  req_pad_s;
  logic [MAX_REQ-1:0]  grant_pad_s;
  logic [REQ_ID_W:0]   pos_s;
  logic                found_s;

  // Scan requesters starting at ptr; padding keeps indexing width-exact for any N_REQ.
  always_comb begin
    req_pad_s              = '0;
    req_pad_s[N_REQ-1:0]   = req;
    grant_pad_s            = '0;
    idx                    = '0;
    pos_s                  = '0;
    found_s                = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      pos_s = {1'b0, ptr} + (REQ_ID_W+1)'(k);
      if (pos_s >= (REQ_ID_W+1)'(N_REQ)) begin
        pos_s = pos_s - (REQ_ID_W+1)'(N_REQ);
      end else begin
        pos_s = pos_s;
      end
      if (en && !found_s && req_pad_s[pos_s[REQ_ID_W-1:0]]) begin
        grant_pad_s[pos_s[REQ_ID_W-1:0]] = 1'b1;
        idx                              = pos_s[REQ_ID_W-1:0];
        found_s                          = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign grant = grant_pad_s[N_REQ-1:0];

endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one AES-128 core between N_REQ requesters: round-robin grant, launch with
// start pulse, wait for done under a watchdog, return a tagged response.
module aes_core_arbiter
  import aes_ctrl_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic               pi_clk,
  input logic               pi_rst_n,
  aes_core_arbiter_if.slave bus
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [2:0]           state_r;
  logic [REQ_ID_W-1:0]  rr_ptr_r;
  logic [REQ_ID_W-1:0]  id_r;
  logic [REQ_ID_W-1:0]  win_idx_s;
  logic [N_REQ-1:0]     grant_s;
  logic [AES_BLK_W-1:0] key_r;
  logic [AES_BLK_W-1:0] data_r;
  logic [AES_BLK_W-1:0] last_key_r;
  logic [AES_BLK_W-1:0] rsp_data_r;
  logic [AES_BLK_W-1:0] sel_key_s;
  logic [AES_BLK_W-1:0] sel_data_s;
  logic [15:0]          cnt_r;
  logic                 first_job_r;
  logic                 start_r;
  logic                 key_change_r;
  logic                 rsp_valid_r;
  logic                 rsp_err_r;
  logic                 busy_r;
  logic                 idle_s;
  logic                 accept_s;

  // Grants are only offered while idle and out of reset so ready is 0 during reset.
  assign idle_s   = (state_r == ST_IDLE) && pi_rst_n;
  assign accept_s = |(bus.pi_req_valid & grant_s);

  aes_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req   (bus.pi_req_valid),
    .ptr   (rr_ptr_r),
    .en    (idle_s),
    .grant (grant_s),
    .idx   (win_idx_s)
  );

  // Select the winning requester's key and plaintext.
  always_comb begin
    sel_key_s  = '0;
    sel_data_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx_s == REQ_ID_W'(i)) begin
        sel_key_s  = bus.pi_req_key[AES_BLK_W*i +: AES_BLK_W];
        sel_data_s = bus.pi_req_data[AES_BLK_W*i +: AES_BLK_W];
      end else begin
        sel_key_s  = sel_key_s;
        sel_data_s = sel_data_s;
      end
    end
  end

  // Job FSM with watchdog; start/key_change are set on accept so they are high only in LAUNCH.
  always_ff @(posedge pi_clk or negedge pi_rst_n) begin
    if (!pi_rst_n) begin
      state_r      <= ST_IDLE;
      rr_ptr_r     <= '0;
      id_r         <= '0;
      key_r        <= '0;
      data_r       <= '0;
      last_key_r   <= '0;
      rsp_data_r   <= '0;
      cnt_r        <= '0;
      first_job_r  <= 1'b1;
      start_r      <= 1'b0;
      key_change_r <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_err_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      start_r      <= 1'b0;
      key_change_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            key_r        <= sel_key_s;
            data_r       <= sel_data_s;
            id_r         <= win_idx_s;
            start_r      <= 1'b1;
            key_change_r <= first_job_r || (sel_key_s != last_key_r);
            busy_r       <= 1'b1;
            state_r      <= ST_LAUNCH;
          end else begin
            state_r      <= ST_IDLE;
          end
        end
        ST_LAUNCH: begin
          last_key_r  <= key_r;
          first_job_r <= 1'b0;
          cnt_r       <= '0;
          state_r     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.pi_core_done) begin
            rsp_data_r  <= bus.pi_core_data;
            rsp_err_r   <= 1'b0;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end else if (cnt_r == TIMEOUT_LAST) begin
            rsp_data_r  <= '0;
            rsp_err_r   <= 1'b1;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end else begin
            cnt_r       <= cnt_r + 16'd1;
          end
        end
        ST_RESP: begin
          if (bus.pi_rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rr_ptr_r    <= rr_next(id_r, N_REQ);
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r     <= ST_RESP;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.po_req_ready       = grant_s;
  assign bus.po_core_key        = key_r;
  assign bus.po_core_data       = data_r;
  assign bus.po_core_start      = start_r;
  assign bus.po_core_key_change = key_change_r;
  assign bus.po_rsp_valid       = rsp_valid_r;
  assign bus.po_rsp_id          = id_r;
  assign bus.po_rsp_data        = rsp_data_r;
  assign bus.po_rsp_error       = rsp_err_r;
  assign bus.po_busy            = busy_r;

endmodule
